// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg: shared types and constants for the instruction prefetch queue.
//   ifq_state_t  - fetch FSM states (FETCH, DISCARD)
//   ifq_entry_t  - queued payload {pc, instr}
//   IFQ_NOP      - instruction/pc4 value presented when the head is empty
//   IFQ_PC_STEP  - sequential fetch stride in bytes
package ifetch_queue_pkg;

   localparam int unsigned IFQ_XLEN = 32;

   localparam logic [IFQ_XLEN-1:0] IFQ_NOP     = 32'h0;
   localparam logic [IFQ_XLEN-1:0] IFQ_PC_STEP = 32'd4;

   typedef enum logic {
      FETCH   = 1'b0,
      DISCARD = 1'b1
   } ifq_state_t;

   typedef struct packed {
      logic [IFQ_XLEN-1:0] pc;
      logic [IFQ_XLEN-1:0] instr;
   } ifq_entry_t;

   // Fetch addresses are always word aligned.
   function automatic logic [IFQ_XLEN-1:0] ifq_align(input logic [IFQ_XLEN-1:0] a);
      return {a[IFQ_XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: DEPTH-entry circular buffer of fetched {pc, instr} entries.
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   clear         drop every entry (redirect flush); wins over push/pop
//   push, wdata   write one entry at the tail (ignored when full)
//   pop           retire the head entry (ignored when empty)
//   rdata         head entry, straight from storage
//   empty, count  occupancy
module ifq_fifo
   import ifetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         push,
   input  ifq_entry_t                   wdata,
   input  logic                         pop,
   output ifq_entry_t                   rdata,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   ifq_entry_t      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   cnt;
   logic            push_ok;
   logic            pop_ok;

   assign push_ok = push && (cnt != CW'(DEPTH));
   assign pop_ok  = pop && (cnt != '0);

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
      end
   end

   // Entry storage needs no reset: occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push_ok && !clear && !reset) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign empty = (cnt == '0);
   assign count = cnt;

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction prefetch queue between a variable-latency imem port
// and the IF/ID register. Issues sequential word fetches, buffers up to DEPTH
// {pc, instr} entries, presents the head as instr/pc+4 under the wpcir stall,
// and flushes/refetches on an ID-stage redirect.
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   redirect, redirect_pc   taken branch/jump and its target (bits [1:0] ignored)
//   stall                   1 = consumer does not take the head this cycle
//   mem_req, mem_addr       imem request; held stable until mem_ack
//   mem_ack, mem_rdata      imem completion and fetched word
//   valid_out, instr_out,   head entry; instr/pc4 read as 0 when not valid
//   pc4_out
// Configuration:
//   IFETCH_QUEUE_BYPASS_EN  when defined, an ack into an empty queue is presented
//                           on the outputs in the same cycle.
module ifetch_queue
   import ifetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        valid_out,
   output logic [31:0] instr_out,
   output logic [31:0] pc4_out
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   ifq_state_t    state, state_n;
   logic          req_n;
   logic [31:0]   addr_n;
   logic [31:0]   saved_pc, saved_pc_n;

   logic          fifo_push, fifo_pop, fifo_clear, fifo_empty;
   ifq_entry_t    fifo_wdata, head;
   logic [CW-1:0] fifo_count, count_n;

   logic          ack_ok;
   logic          byp_valid;
   logic          byp_take;
   logic [31:0]   target_pc;

   assign ack_ok    = mem_req && mem_ack;
   assign target_pc = ifq_align(redirect_pc);

`ifdef IFETCH_QUEUE_BYPASS_EN
   // An ack arriving while nothing is buffered goes straight to the outputs.
   assign byp_valid = fifo_empty && (state == FETCH) && ack_ok && !redirect;
`else
   assign byp_valid = 1'b0;
`endif
   assign byp_take  = byp_valid && !stall;

   assign fifo_wdata = '{pc: mem_addr, instr: mem_rdata};

   ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (fifo_clear),
      .push  (fifo_push),
      .wdata (fifo_wdata),
      .pop   (fifo_pop),
      .rdata (head),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // State, request and address registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= FETCH;
         mem_req  <= 1'b0;
         mem_addr <= RESET_PC;
         saved_pc <= RESET_PC;
      end else begin
         state    <= state_n;
         mem_req  <= req_n;
         mem_addr <= addr_n;
         saved_pc <= saved_pc_n;
      end
   end

   // Next-state, handshake and queue control.
   always_comb begin
      state_n    = state;
      req_n      = mem_req;
      addr_n     = mem_addr;
      saved_pc_n = saved_pc;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
      fifo_clear = 1'b0;
      count_n    = fifo_count;

      unique case (state)
         FETCH: begin
            if (redirect) begin
               fifo_clear = 1'b1;
               if (!mem_req || mem_ack) begin
                  // Nothing in flight (or it completes now): refetch at once.
                  addr_n = target_pc;
                  req_n  = 1'b1;
               end else begin
                  // Must finish the in-flight request before moving the address.
                  state_n    = DISCARD;
                  saved_pc_n = target_pc;
               end
            end else begin
               fifo_pop = !fifo_empty && !stall;
               if (ack_ok) begin
                  fifo_push = !byp_take;
                  addr_n    = mem_addr + IFQ_PC_STEP;
               end
               count_n = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
               // Only issue when the returning word is guaranteed a slot.
               req_n = (count_n < CW'(DEPTH));
            end
         end
         DISCARD: begin
            fifo_clear = redirect;
            if (redirect) saved_pc_n = target_pc;
            if (ack_ok) begin
               state_n = FETCH;
               addr_n  = redirect ? target_pc : saved_pc;
               req_n   = 1'b1;
            end
         end
         default: begin
            state_n = FETCH;
         end
      endcase
   end

   // Head presentation; the bypass word takes over only when the queue is empty.
   always_comb begin
      valid_out = !fifo_empty;
      instr_out = fifo_empty ? IFQ_NOP : head.instr;
      pc4_out   = fifo_empty ? IFQ_NOP : head.pc + IFQ_PC_STEP;
      if (byp_valid) begin
         valid_out = 1'b1;
         instr_out = mem_rdata;
         pc4_out   = mem_addr + IFQ_PC_STEP;
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed self-checking bench for ifetch_queue (DEPTH=4, RESET_PC=0).
// A queue-level reference model tracks the expected request/address and a
// scoreboard of fetched words that should reach the outputs in order.
module tb_ifetch_queue;

   localparam int unsigned DEPTH = 4;
`ifdef IFETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] ins;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        valid_out;
   logic [31:0] instr_out;
   logic [31:0] pc4_out;

   int total = 0;
   int bad   = 0;

   exp_t        sb[$];
   logic        m_req;
   logic [31:0] m_addr;
   logic        m_disc;
   logic [31:0] m_saved;

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   assign mem_rdata = memf(mem_addr);

   ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk         (clk),
      .reset       (reset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .valid_out   (valid_out),
      .instr_out   (instr_out),
      .pc4_out     (pc4_out)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One clock: settle inputs, compare against the model, advance the model, clock.
   task automatic cyc();
      exp_t e;
      bit   byp;
      bit   acc;
      #1;
      chk("mem_req", 32'(mem_req), 32'(m_req));
      chk("mem_addr", mem_addr, m_addr);
      byp = BYP && !m_disc && (sb.size() == 0) && m_req && mem_ack && !redirect;
      if (byp)                e = '{pc4: m_addr + 32'd4, ins: memf(m_addr)};
      else if (sb.size() > 0) e = sb[0];
      else                    e = '{pc4: 32'h0, ins: 32'h0};
      chk("valid_out", 32'(valid_out), 32'(byp || (sb.size() > 0)));
      chk("instr_out", instr_out, e.ins);
      chk("pc4_out", pc4_out, e.pc4);
      acc = m_req && mem_ack;
      if (!m_disc) begin
         if (redirect) begin
            sb.delete();
            if (!m_req || mem_ack) m_addr = {redirect_pc[31:2], 2'b00};
            else begin
               m_disc  = 1'b1;
               m_saved = {redirect_pc[31:2], 2'b00};
            end
            m_req = 1'b1;
         end else begin
            if ((sb.size() > 0) && !stall) void'(sb.pop_front());
            if (acc) begin
               if (!(byp && !stall)) sb.push_back('{pc4: m_addr + 32'd4, ins: memf(m_addr)});
               m_addr = m_addr + 32'd4;
            end
            m_req = (sb.size() < DEPTH);
         end
      end else begin
         if (redirect) m_saved = {redirect_pc[31:2], 2'b00};
         if (acc) begin
            m_addr = redirect ? {redirect_pc[31:2], 2'b00} : m_saved;
            m_disc = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n, input logic ack, input logic stl);
      mem_ack  = ack;
      stall    = stl;
      redirect = 1'b0;
      repeat (n) cyc();
   endtask

   // Reset held with an ack pending: reset must win and the ack must be ignored.
   task automatic do_reset();
      reset    = 1'b1;
      redirect = 1'b0;
      stall    = 1'b0;
      mem_ack  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_valid", 32'(valid_out), 32'h0);
      chk("rst_instr", instr_out, 32'h0);
      chk("rst_pc4", pc4_out, 32'h0);
      sb.delete();
      m_req   = 1'b0;
      m_addr  = 32'h0;
      m_disc  = 1'b0;
      m_saved = 32'h0;
      reset   = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      stall       = 1'b0;
      mem_ack     = 1'b0;

      // 1: ack tied high straight out of reset.
      do_reset();
      run(1, 1'b1, 1'b0);
      chk("t1_req_c1", 32'(mem_req), 32'h1);
      chk("t1_addr_c1", mem_addr, 32'h0);
      run(1, 1'b1, 1'b0);
      if (!BYP) begin
         chk("t1_valid_c2", 32'(valid_out), 32'h1);
         chk("t1_instr_c2", instr_out, memf(32'h0));
         chk("t1_pc4_c2", pc4_out, 32'h4);
      end
      run(6, 1'b1, 1'b0);

      // 2: stall fills the queue exactly to DEPTH, then drains in order.
      do_reset();
      run(10, 1'b1, 1'b1);
      chk("t2_req_full", 32'(mem_req), 32'h0);
      mem_ack = 1'b0;
      stall   = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("t2_pop_pc4", pc4_out, 32'(4 * (k + 1)));
         cyc();
      end
      chk("t2_drained", 32'(valid_out), 32'h0);
      run(4, 1'b0, 1'b0);

      // 3: ack delayed three cycles; request held stable, one push only.
      do_reset();
      run(1, 1'b0, 1'b1);
      run(3, 1'b0, 1'b1);
      run(1, 1'b1, 1'b1);
      run(3, 1'b0, 1'b1);
      chk("t3_one_push_pc4", pc4_out, 32'h4);
      run(3, 1'b0, 1'b0);

      // 4: redirect while the 0x8 request is unacked, then a second redirect wins.
      do_reset();
      run(3, 1'b1, 1'b1);
      mem_ack     = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h80;
      cyc();
      chk("t4_flush_valid", 32'(valid_out), 32'h0);
      redirect_pc = 32'h40;
      cyc();
      redirect = 1'b0;
      run(1, 1'b0, 1'b1);
      chk("t4_disc_addr", mem_addr, 32'h8);
      run(1, 1'b1, 1'b1);
      chk("t4_new_addr", mem_addr, 32'h40);
      run(1, 1'b1, 1'b1);
      chk("t4_first_pc4", pc4_out, 32'h44);
      run(6, 1'b1, 1'b0);

      // 5: redirect and pop in the same cycle with three entries queued.
      do_reset();
      run(4, 1'b1, 1'b1);
      stall       = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      cyc();
      chk("t5_flush_valid", 32'(valid_out), 32'h0);
      chk("t5_next_addr", mem_addr, 32'h100);
      run(6, 1'b1, 1'b0);

      // 6: first ack into an empty queue with stall low.
      do_reset();
      run(2, 1'b0, 1'b0);
      mem_ack = 1'b1;
      #1;
      chk("t6_ack_cycle_valid", 32'(valid_out), 32'(BYP));
      cyc();
      mem_ack = 1'b0;
      #1;
      chk("t6_after_valid", 32'(valid_out), 32'(!BYP));
      run(3, 1'b0, 1'b0);

      // 7: misaligned target near the top of memory; address wraps to 0.
      do_reset();
      run(2, 1'b1, 1'b1);
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFB;
      mem_ack     = 1'b1;
      cyc();
      chk("t7_aligned", mem_addr, 32'hFFFF_FFF8);
      run(3, 1'b1, 1'b1);
      chk("t7_wrap_addr", mem_addr, 32'h4);
      run(8, 1'b1, 1'b0);

      // 8: random mix of acks, stalls and redirects against the model.
      do_reset();
      for (int i = 0; i < 200; i++) begin
         mem_ack     = ($urandom_range(0, 2) != 0);
         stall       = ($urandom_range(0, 2) == 0);
         redirect    = ($urandom_range(0, 15) == 0);
         redirect_pc = $urandom;
         cyc();
      end
      run(10, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
